// File: rtl/ss_scan_ctrl_if.sv
// rtl/ss_scan_ctrl_if.sv - display data and scan output bundle for ss_scan_ctrl
interface ss_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      enable;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp_mask;
    logic [3:0]                digit_nib;
    logic [NUM_DIGITS-1:0]     an;
    logic                      dp_n;
    logic                      load_ack;
    logic                      frame_start;

    modport master (
        output enable, load, value, dp_mask,
        input  digit_nib, an, dp_n, load_ack, frame_start
    );

    modport slave (
        input  enable, load, value, dp_mask,
        output digit_nib, an, dp_n, load_ack, frame_start
    );
endinterface

// File: rtl/ss_scan_ctrl.sv
// rtl/ss_scan_ctrl.sv - seven-segment scan controller with blanking gap and frame-synchronous commit
// Optional leading-zero blanking is built when SS_LZB_EN is defined.
module ss_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000,
    parameter int BLANK_CYC  = 100
) (
    input  logic          clk,
    input  logic          rst_n,
    ss_scan_ctrl_if.slave bus
);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_e;

    state_e                    state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic                      pend_q, pend_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]   disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic [3:0]                nib_q, nib_d;
    logic                      dp_n_q, dp_n_d;
    logic                      ack_q, ack_d;
    logic                      fs_q, fs_d;
    logic                      boundary;
    logic                      cur_blank;

`ifdef SS_LZB_EN
    logic [NUM_DIGITS-1:0]     blank_q, blank_d;

    // Scan down from the top digit; any nonzero nibble or lit DP ends the blanked run.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [4*NUM_DIGITS-1:0] v,
                                                       input logic [NUM_DIGITS-1:0]   dp);
        logic run;
        run      = 1'b1;
        lzb_mask = '0;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            run         = run & (v[4*k +: 4] == 4'd0) & ~dp[k];
            lzb_mask[k] = run;
        end
    endfunction
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        boundary   = 1'b0;
        cur_blank  = 1'b0;
`ifdef SS_LZB_EN
        blank_d    = blank_q;
`endif

        if (bus.load) begin
            pend_val_d = bus.value;
            pend_dp_d  = bus.dp_mask;
            pend_d     = 1'b1;
        end

        if (!bus.enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = BLANK;
                    cnt_d    = '0;
                    idx_d    = '0;
                    boundary = 1'b1;
                end
                BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BLANK_LAST) state_d = DRIVE;
                end
                DRIVE: begin
                    if (cnt_q == SLOT_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // pend_*_d already holds a same-cycle load, which gives the bypass commit for free.
        ack_d = boundary & pend_d;
        if (ack_d) begin
            disp_val_d = pend_val_d;
            disp_dp_d  = pend_dp_d;
            pend_d     = 1'b0;
`ifdef SS_LZB_EN
            blank_d    = lzb_mask(pend_val_d, pend_dp_d);
`endif
        end

`ifdef SS_LZB_EN
        cur_blank = blank_d[idx_d];
`endif

        fs_d   = boundary;
        an_d   = '1;
        dp_n_d = 1'b1;
        nib_d  = 4'd0;
        if (state_d != IDLE) begin
            nib_d  = disp_val_d[{idx_d, 2'b00} +: 4];
            dp_n_d = ~disp_dp_d[idx_d] | cur_blank;
            if (state_d == DRIVE && !cur_blank) an_d = ~(NUM_DIGITS'(1) << idx_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            pend_q     <= 1'b0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            disp_val_q <= '0;
            disp_dp_q  <= '0;
            an_q       <= '1;
            nib_q      <= 4'd0;
            dp_n_q     <= 1'b1;
            ack_q      <= 1'b0;
            fs_q       <= 1'b0;
`ifdef SS_LZB_EN
            blank_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            disp_val_q <= disp_val_d;
            disp_dp_q  <= disp_dp_d;
            an_q       <= an_d;
            nib_q      <= nib_d;
            dp_n_q     <= dp_n_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
`ifdef SS_LZB_EN
            blank_q    <= blank_d;
`endif
        end
    end

    assign bus.an          = an_q;
    assign bus.digit_nib   = nib_q;
    assign bus.dp_n        = dp_n_q;
    assign bus.load_ack    = ack_q;
    assign bus.frame_start = fs_q;
endmodule
